// File: rtl/heat_writeback_if.sv
// Bundle for the heat_writeback block: step control, result stream from the
// stencil pipeline, the published-row read port, and status.
// The master drives step control, results and read address; the slave
// (heat_writeback) drives read data and status.
interface heat_writeback_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
);
    logic              step_start;
    logic              res_valid;
    logic [IDX_W-1:0]  res_idx;
    logic [DATA_W-1:0] res_data;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              step_done;
    logic [15:0]       step_count;
    logic              err_range;
    logic              err_dup;

    modport master (
        output step_start, res_valid, res_idx, res_data, rd_idx,
        input  rd_data, busy, step_done, step_count, err_range, err_dup
    );

    modport slave (
        input  step_start, res_valid, res_idx, res_data, rd_idx,
        output rd_data, busy, step_done, step_count, err_range, err_dup
    );
endinterface

// File: rtl/heat_writeback.sv
// heat_writeback: double-buffered temperature row for a 1-D heat stencil.
// Results for interior nodes are collected into the hidden bank; once every
// interior node has been written the banks swap and the new row is published.
// Boundary nodes hold their reset value forever (fixed Dirichlet boundary).
// Optional build macro: HEAT_WB_CLAMP_EN -- negative results are stored as +0.0.
module heat_writeback #(
    parameter int N_NODES = 10,
    parameter int DATA_W  = 32,
    parameter int IDX_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    heat_writeback_if.slave    bus
);

    localparam logic [DATA_W-1:0]  EDGE_INIT     = DATA_W'(32'h3F800000);
    localparam logic [DATA_W-1:0]  INTERIOR_INIT = DATA_W'(32'h3E4CCCCD);
    localparam logic [N_NODES-1:0] INTERIOR_MASK = {1'b0, {(N_NODES-2){1'b1}}, 1'b0};
    localparam logic [IDX_W-1:0]   FIRST_INT     = IDX_W'(1);
    localparam logic [IDX_W-1:0]   LAST_INT      = IDX_W'(N_NODES - 2);
    localparam logic [IDX_W:0]     NODES_EXT     = (IDX_W+1)'(N_NODES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SWAP    = 2'd2
    } state_t;

    state_t              state_reg;
    logic                cur_bank_reg;      // 0: bank A published, 1: bank B published
    logic [N_NODES-1:0]  mask_reg;
    logic                step_done_reg;
    logic [15:0]         step_count_reg;
    logic                err_range_reg;
    logic                err_dup_reg;
    logic [DATA_W-1:0]   rd_data_reg;

    logic [DATA_W-1:0]   bank_a_reg [N_NODES];
    logic [DATA_W-1:0]   bank_b_reg [N_NODES];

    logic [N_NODES-1:0]  node_sel;
    logic                is_interior;
    logic                wr_en;
    logic                range_evt;
    logic                dup_evt;
    logic                mask_full;
    logic [DATA_W-1:0]   wr_data;

    // One-hot decode of the result index
    genvar gi;
    generate
        for (gi = 0; gi < N_NODES; gi++) begin : g_sel
            assign node_sel[gi] = (bus.res_idx == IDX_W'(gi));
        end
    endgenerate

    // Classify the incoming result: accepted write, range error or duplicate.
    // A result coinciding with a restart is silently dropped.
    always_comb begin
        is_interior = (bus.res_idx >= FIRST_INT) && (bus.res_idx <= LAST_INT);
        wr_en       = bus.res_valid && (state_reg == COLLECT) && !bus.step_start && is_interior;
        range_evt   = bus.res_valid &&
                      ((state_reg != COLLECT) || (!bus.step_start && !is_interior));
        dup_evt     = wr_en && ((mask_reg & node_sel) != '0);
        mask_full   = ((mask_reg & INTERIOR_MASK) == INTERIOR_MASK);
`ifdef HEAT_WB_CLAMP_EN
        wr_data     = bus.res_data[DATA_W-1] ? '0 : bus.res_data;
`else
        wr_data     = bus.res_data;
`endif
    end

    // Step sequencing, mask tracking, bank select and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cur_bank_reg   <= 1'b0;
            mask_reg       <= '0;
            step_done_reg  <= 1'b0;
            step_count_reg <= '0;
            err_range_reg  <= 1'b0;
            err_dup_reg    <= 1'b0;
        end else begin
            step_done_reg <= 1'b0;
            if (range_evt) err_range_reg <= 1'b1;
            if (dup_evt)   err_dup_reg   <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (bus.step_start) begin
                        state_reg <= COLLECT;
                        mask_reg  <= '0;
                    end
                end
                COLLECT: begin
                    if (bus.step_start) begin
                        mask_reg <= '0;                 // abort and restart the step
                    end else if (mask_full) begin
                        state_reg      <= SWAP;
                        step_done_reg  <= 1'b1;
                        step_count_reg <= step_count_reg + 16'd1;
                        mask_reg       <= '0;
                    end else if (wr_en) begin
                        mask_reg <= mask_reg | node_sel;
                    end
                end
                SWAP: begin
                    // Readers see the old row for the whole SWAP cycle
                    state_reg    <= IDLE;
                    cur_bank_reg <= ~cur_bank_reg;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Row storage: writes always target the hidden bank; boundaries never change
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_NODES; i++) begin
            if (rst) begin
                bank_a_reg[i] <= INTERIOR_MASK[i] ? INTERIOR_INIT : EDGE_INIT;
                bank_b_reg[i] <= INTERIOR_MASK[i] ? INTERIOR_INIT : EDGE_INIT;
            end else if (wr_en && node_sel[i] && INTERIOR_MASK[i]) begin
                if (cur_bank_reg) bank_a_reg[i] <= wr_data;
                else              bank_b_reg[i] <= wr_data;
            end
        end
    end

    // Registered read of the published row; out-of-range addresses read zero
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else if ({1'b0, bus.rd_idx} < NODES_EXT) begin
            rd_data_reg <= cur_bank_reg ? bank_b_reg[bus.rd_idx] : bank_a_reg[bus.rd_idx];
        end else begin
            rd_data_reg <= '0;
        end
    end

    assign bus.busy       = (state_reg != IDLE);
    assign bus.step_done  = step_done_reg;
    assign bus.step_count = step_count_reg;
    assign bus.err_range  = err_range_reg;
    assign bus.err_dup    = err_dup_reg;
    assign bus.rd_data    = rd_data_reg;

endmodule

// File: tb/tb_heat_writeback.sv
// Self-checking bench for heat_writeback: a behavioural row model feeds a
// read scoreboard; each scenario task drives stimulus and checks inline.
module tb_heat_writeback;

    localparam int N = 10;
    localparam logic [31:0] ONE  = 32'h3F800000;
    localparam logic [31:0] PT2  = 32'h3E4CCCCD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    heat_writeback_if #(.DATA_W(32), .IDX_W(4)) bus ();

    heat_writeback #(.N_NODES(N), .DATA_W(32), .IDX_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int done_pulses  = 0;

    // Behavioural model of the published/hidden rows
    logic [31:0] m_bank [2][N];
    int          m_cur;
    logic [15:0] m_count;
    bit          m_collect;
    bit [N-1:0]  m_mask;
    bit          m_err_range;
    bit          m_err_dup;
    logic [31:0] exp_q [$];

    always @(negedge clk) if (!rst && bus.step_done) done_pulses++;

    function automatic logic [31:0] m_clamp(input logic [31:0] d);
`ifdef HEAT_WB_CLAMP_EN
        return d[31] ? 32'h0 : d;
`else
        return d;
`endif
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < N; i++)
                m_bank[b][i] = (i == 0 || i == N-1) ? ONE : PT2;
        m_cur = 0; m_count = 0; m_collect = 0; m_mask = '0;
        m_err_range = 0; m_err_dup = 0;
    endtask

    task automatic model_swap();
        m_count++;
        m_cur = 1 - m_cur;
        m_collect = 0;
        m_mask = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.step_start = 0; bus.res_valid = 0; bus.res_idx = '0;
        bus.res_data = '0; bus.rd_idx = '0;
        cycle(); cycle();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wr(input int idx, input logic [31:0] d);
        bus.res_valid = 1'b1;
        bus.res_idx   = 4'(idx);
        bus.res_data  = d;
        if (m_collect && idx >= 1 && idx <= N-2) begin
            if (m_mask[idx]) m_err_dup = 1;
            m_mask[idx] = 1;
            m_bank[1-m_cur][idx] = m_clamp(d);
        end else begin
            m_err_range = 1;
        end
        cycle();
        bus.res_valid = 1'b0;
    endtask

    task automatic start_step();
        bus.step_start = 1'b1;
        m_collect = 1;
        m_mask = '0;
        cycle();
        bus.step_start = 1'b0;
    endtask

    task automatic sb_read(input int idx);
        logic [31:0] e;
        exp_q.push_back((idx < N) ? m_bank[m_cur][idx] : 32'h0);
        bus.rd_idx = 4'(idx);
        cycle();
        e = exp_q.pop_front();
        tests_run++;
        if (bus.rd_data !== e) begin
            tests_failed++;
            $display("FAIL rd_idx_%0d: got %h expected %h", idx, bus.rd_data, e);
        end else
            $display("[TB] read idx %0d = %h", idx, bus.rd_data);
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int c = 0; c < 8 && !seen; c++) begin
            cycle();
            if (bus.step_done === 1'b1) seen = 1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL %s_done: step_done not seen within 8 cycles (required 1)", name);
        end else begin
            if (bus.step_count !== m_count + 16'd1) begin
                tests_failed++;
                $display("FAIL %s_count: got %0d expected %0d", name, bus.step_count, m_count + 16'd1);
            end else
                $display("[TB] %s step_done, step_count=%0d", name, bus.step_count);
            cycle();   // leave SWAP
        end
        model_swap();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.step_start = 0; bus.res_valid = 0; bus.res_idx = '0;
        bus.res_data = '0; bus.rd_idx = '0;
        cycle(); cycle();
        tests_run++;
        if (bus.rd_data !== 32'h0 || bus.busy !== 1'b0 || bus.step_done !== 1'b0 ||
            bus.step_count !== 16'd0 || bus.err_range !== 1'b0 || bus.err_dup !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: rd=%h busy=%b done=%b cnt=%0d er=%b ed=%b required all 0",
                     bus.rd_data, bus.busy, bus.step_done, bus.step_count, bus.err_range, bus.err_dup);
        end else
            $display("[TB] reset state ok");
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) sb_read(i);
        sb_read(12);
    endtask

    task automatic test_in_order();
        logic [31:0] old5;
        start_step();
        tests_run++;
        if (bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL in_order_busy: got %b expected 1", bus.busy);
        end
        for (int i = 1; i <= N-2; i++) wr(i, 32'h40000000);
        tests_run++;
        if (bus.step_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL in_order_early_done: got %b expected 0", bus.step_done);
        end
        old5 = m_bank[m_cur][5];
        bus.rd_idx = 4'd5;
        cycle();                       // now in SWAP
        tests_run++;
        if (bus.step_done !== 1'b1 || bus.step_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL in_order_done: done=%b cnt=%0d expected done=1 cnt=1", bus.step_done, bus.step_count);
        end else
            $display("[TB] in_order step_done two cycles after last write");
        cycle();                       // read sampled during SWAP
        tests_run++;
        if (bus.rd_data !== old5 || bus.step_done !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL swap_read: rd=%h done=%b busy=%b expected rd=%h done=0 busy=0",
                     bus.rd_data, bus.step_done, bus.busy, old5);
        end else
            $display("[TB] swap-cycle read returns old row %h", bus.rd_data);
        model_swap();
        sb_read(5);
        sb_read(0);
        sb_read(9);
    endtask

    task automatic test_gaps();
        int d0 = done_pulses;
        start_step();
        for (int i = N-2; i >= 1; i--) begin
            wr(i, 32'h40400000 + 32'(i));
            cycle(); cycle(); cycle();
        end
        cycle(); cycle();
        tests_run++;
        if (done_pulses - d0 !== 1 || bus.step_count !== m_count + 16'd1) begin
            tests_failed++;
            $display("FAIL gaps_done: pulses=%0d cnt=%0d expected 1 and %0d",
                     done_pulses - d0, bus.step_count, m_count + 16'd1);
        end else
            $display("[TB] gaps single step_done");
        model_swap();
        tests_run++;
        if (bus.err_range !== 1'b0 || bus.err_dup !== 1'b0) begin
            tests_failed++;
            $display("FAIL gaps_err: er=%b ed=%b expected 0 0", bus.err_range, bus.err_dup);
        end
        sb_read(8); sb_read(1); sb_read(4);
    endtask

    task automatic test_restart();
        int d0 = done_pulses;
        start_step();
        for (int i = 1; i <= 4; i++) wr(i, 32'h41000000);
        start_step();
        for (int i = 5; i <= 8; i++) wr(i, 32'h41200000);
        repeat (6) cycle();
        tests_run++;
        if (done_pulses !== d0 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_hold: pulses=%0d busy=%b expected 0 new and busy 1", done_pulses - d0, bus.busy);
        end else
            $display("[TB] restart held step open");
        for (int i = 1; i <= 4; i++) wr(i, 32'h41100000);
        wait_done("restart");
        tests_run++;
        if (bus.err_range !== 1'b0 || bus.err_dup !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart_err: er=%b ed=%b expected 0 0", bus.err_range, bus.err_dup);
        end
        sb_read(2); sb_read(6);
    endtask

    task automatic test_clamp();
        start_step();
        wr(2, 32'hBF000000);
        wr(1, 32'h3F000000);
        for (int i = 3; i <= 8; i++) wr(i, 32'h3F000000);
        wait_done("clamp");
        sb_read(2);
        sb_read(3);
    endtask

    task automatic test_errors();
        int d0 = done_pulses;
        start_step();
        wr(0, 32'h12345678);
        wr(9, 32'h12345678);
        wr(12, 32'h12345678);
        tests_run++;
        if (bus.err_range !== 1'b1 || bus.err_dup !== 1'b0) begin
            tests_failed++;
            $display("FAIL range_err: er=%b ed=%b expected 1 0", bus.err_range, bus.err_dup);
        end else
            $display("[TB] range errors flagged");
        wr(3, 32'h40A00000);
        wr(3, 32'h40C00000);
        tests_run++;
        if (bus.err_dup !== 1'b1 || done_pulses !== d0) begin
            tests_failed++;
            $display("FAIL dup_err: ed=%b new_pulses=%0d expected 1 0", bus.err_dup, done_pulses - d0);
        end else
            $display("[TB] duplicate flagged");
        wr(1, 32'h40E00000); wr(2, 32'h40E00000);
        for (int i = 4; i <= 8; i++) wr(i, 32'h40E00000);
        wait_done("errors");
        sb_read(0); sb_read(9); sb_read(3);
    endtask

    task automatic test_reset_mid();
        do_reset();
        start_step();
        for (int i = 1; i <= 4; i++) wr(i, 32'h41800000);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        model_reset();
        tests_run++;
        if (bus.busy !== 1'b0 || bus.step_count !== 16'd0 || bus.err_range !== 1'b0 || bus.err_dup !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: busy=%b cnt=%0d er=%b ed=%b expected 0", bus.busy, bus.step_count, bus.err_range, bus.err_dup);
        end else
            $display("[TB] mid-step reset discarded partial step");
        for (int i = 1; i <= 4; i++) sb_read(i);
    endtask

    task automatic test_back_to_back();
        wr(4, 32'h42000000);           // IDLE write: dropped, range error
        tests_run++;
        if (bus.err_range !== 1'b1 || bus.err_dup !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_write: er=%b ed=%b expected 1 0", bus.err_range, bus.err_dup);
        end
        sb_read(4);
        start_step();
        for (int i = 1; i <= 8; i++) wr(i, 32'h42100000);
        cycle();                       // SWAP
        bus.step_start = 1'b1;         // ignored in SWAP
        cycle();
        bus.step_start = 1'b0;
        model_swap();
        tests_run++;
        if (bus.busy !== 1'b0 || bus.step_count !== m_count) begin
            tests_failed++;
            $display("FAIL swap_start_ignored: busy=%b cnt=%0d expected 0 %0d", bus.busy, bus.step_count, m_count);
        end else
            $display("[TB] step_start in SWAP ignored");
        start_step();
        for (int i = 8; i >= 1; i--) wr(i, 32'h42200000 + 32'(i));
        wait_done("b2b");
        sb_read(7); sb_read(4); sb_read(15);
    endtask

    initial begin
        bus.step_start = 0; bus.res_valid = 0; bus.res_idx = '0;
        bus.res_data = '0; bus.rd_idx = '0;
        test_reset();
        test_in_order();
        test_gaps();
        test_restart();
        test_clamp();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (required finish before 200000)");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/heat_writeback.md
HEAT_WRITEBACK -- requirements
Module: heat_writeback

Interface
REQ-001 Parameter N_NODES, default 10, number of grid nodes per temperature row (indices 0..N_NODES-1).
REQ-002 Parameter DATA_W, default 32, IEEE-754 single-precision word width.
REQ-003 Parameter IDX_W, default 4, node index width; SHALL satisfy 2^IDX_W >= N_NODES.
REQ-004 Port list:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- step_start  input  1  one-cycle pulse: begin collecting one time step.
- res_valid  input  1  res_data/res_idx valid this cycle.
- res_idx  input  IDX_W  destination node index of result.
- res_data  input  DATA_W  new node temperature from FP stencil pipeline.
- rd_idx  input  IDX_W  read address into current (published) row.
- rd_data  output  DATA_W  registered read data.
- busy  output  1  high in COLLECT or SWAP.
- step_done  output  1  one-cycle pulse on bank swap.
- step_count  output  16  completed steps, wraps 16'hFFFF->0.
- err_range  output  1  sticky: write to boundary/out-of-range index or while IDLE.
- err_dup  output  1  sticky: same interior index written twice in one step.

Function
REQ-005 Block SHALL hold two banks A/B of N_NODES words; cur_bank selects the published row, writes target the other bank.
REQ-006 FSM states IDLE, COLLECT, SWAP; IDLE->COLLECT on step_start; COLLECT->SWAP the cycle after the written-mask covers all interior nodes 1..N_NODES-2; SWAP->IDLE unconditionally after one cycle.
REQ-007 In COLLECT, res_valid with 1<=res_idx<=N_NODES-2 SHALL write res_data to next bank[res_idx] and set mask bit res_idx.
REQ-008 res_valid with res_idx 0, N_NODES-1 or >=N_NODES SHALL be dropped and set err_range; res_valid in IDLE or SWAP SHALL be dropped and set err_range.
REQ-009 Repeat write to an already-set mask bit SHALL overwrite data and set err_dup.
REQ-010 Results MAY arrive in any index order and with gaps; no backpressure exists.
REQ-011 In SWAP: cur_bank toggles, step_done=1 for exactly that cycle, step_count increments, mask clears.
REQ-012 Boundary words 0 and N_NODES-1 SHALL never be modified after reset (fixed Dirichlet condition).
REQ-013 step_start while in COLLECT SHALL clear the mask and remain in COLLECT (abort/restart); a res_valid in that same cycle SHALL be dropped without error.
REQ-014 step_start in SWAP SHALL be ignored.
REQ-015 rd_data SHALL equal cur_bank[rd_idx] as sampled at the previous rising edge (latency 1); rd_idx >= N_NODES returns 0.
REQ-016 Read during SWAP cycle SHALL return data from the bank selected before the toggle.
REQ-017 busy SHALL be combinationally derived from state (high in COLLECT, SWAP).

Reset
REQ-018 On rst: state IDLE, cur_bank=A, mask=0, step_done=0, step_count=0, err_range=0, err_dup=0, rd_data=0.
REQ-019 On rst both banks: index 0 and N_NODES-1 = 32'h3F800000 (1.0), interior = 32'h3E4CCCCD (0.2).
REQ-020 rst mid-COLLECT SHALL discard partial step; rst has priority over all inputs.

Configuration
REQ-021 Macro HEAT_WB_CLAMP_EN: when defined, res_data with sign bit 1 SHALL be written as 32'h00000000 (clamp to +0.0); when undefined, res_data written unmodified.

Verification
REQ-022 Reset, rd_idx 0..9 -> rd_data 3F800000, then 3E4CCCCD x8, then 3F800000; step_count=0.
REQ-023 step_start, write idx 1..8 with 0x40000000 in order -> step_done pulse 2 cycles after idx 8 write, step_count=1, rd idx 5 = 0x40000000, idx 0 = 3F800000.
REQ-024 Write idx 8 down to 1 with gaps of 3 idle cycles -> single step_done, no errors.
REQ-025 Write idx 0, idx 9, idx 12, then idx 3 twice -> err_range=1, err_dup=1, boundary unchanged, no step_done until 1..8 complete.
REQ-026 Write idx 1..4, assert step_start, then write 5..8 -> no step_done; then write 1..4 -> step_done.
REQ-027 Write res_data 0xBF000000 to idx 2 -> published value 0x00000000 with HEAT_WB_CLAMP_EN, 0xBF000000 without.
